// File: rtl/stoplight_if.sv
// Signal bundle between the stoplight controller and its environment.
interface stoplight_if;
  logic       car_present;
  logic       ped_req;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic       walk;
  logic [2:0] phase;

  // Environment side: drives the sensors and watches the lamps.
  modport master (
    output car_present, ped_req,
    input  light_main, light_side, walk, phase
  );

  // Controller side: reads the sensors and drives the lamps.
  modport slave (
    input  car_present, ped_req,
    output light_main, light_side, walk, phase
  );
endinterface

// File: rtl/stoplight_ctrl.sv
// Two-road traffic-light controller. Main road rests on green and the side
// road is served on demand. A pedestrian request is latched and gives a timed
// walk at the start of the next side green.
module stoplight_ctrl #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned MIN_MAIN_GRN  = 4,
  parameter int unsigned YLW_TICKS     = 1,
  parameter int unsigned ALL_RED_TICKS = 1,
  parameter int unsigned SIDE_MIN_GRN  = 2,
  parameter int unsigned SIDE_MAX_GRN  = 4,
  parameter int unsigned WALK_TICKS    = 3
) (
  input  logic  clk,
  input  logic  rst,
  stoplight_if.slave bus
);

  typedef enum logic [2:0] {
    MAIN_GRN  = 3'd0,
    MAIN_YLW  = 3'd1,
    ALL_RED_A = 3'd2,
    SIDE_GRN  = 3'd3,
    SIDE_YLW  = 3'd4,
    ALL_RED_B = 3'd5
  } state_e;

  localparam logic [2:0] LT_GRN = 3'b100;
  localparam logic [2:0] LT_YLW = 3'b010;
  localparam logic [2:0] LT_RED = 3'b001;

  // The all-red limit is unused when the all-red phases are removed; keep it
  // nonzero so the comparison is never trivially true.
  localparam int unsigned AR_TICKS = (ALL_RED_TICKS == 0) ? 1 : ALL_RED_TICKS;

  localparam logic [CNT_W-1:0] MIN_MAIN_LIM = CNT_W'(MIN_MAIN_GRN);
  localparam logic [CNT_W-1:0] YLW_LIM      = CNT_W'(YLW_TICKS);
  localparam logic [CNT_W-1:0] AR_LIM       = CNT_W'(AR_TICKS);
  localparam logic [CNT_W-1:0] SIDE_MIN_LIM = CNT_W'(SIDE_MIN_GRN);
  localparam logic [CNT_W-1:0] SIDE_MAX_LIM = CNT_W'(SIDE_MAX_GRN);
  localparam logic [CNT_W-1:0] WALK_LIM     = CNT_W'(WALK_TICKS);
  localparam logic [CNT_W-1:0] H_MAX        = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic             ped_pending_q, ped_pending_d;
  logic             serving_q, serving_d;
  logic [2:0]       light_main_q, light_main_d;
  logic [2:0]       light_side_q, light_side_d;
  logic             walk_q, walk_d;
  logic             demand;
  logic             side_entry;
  logic             side_exit;

  // State, hold counter, pedestrian latch and registered lamp outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= MAIN_GRN;
      h_q           <= CNT_W'(1);
      ped_pending_q <= 1'b0;
      serving_q     <= 1'b0;
      light_main_q  <= LT_GRN;
      light_side_q  <= LT_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      ped_pending_q <= ped_pending_d;
      serving_q     <= serving_d;
      light_main_q  <= light_main_d;
      light_side_q  <= light_side_d;
      walk_q        <= walk_d;
    end
  end

  // Phase sequencing, hold counter, pedestrian bookkeeping and lamp decode.
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    ped_pending_d = ped_pending_q;
    serving_d     = serving_q;
    light_main_d  = LT_RED;
    light_side_d  = LT_RED;
    walk_d        = 1'b0;
    demand        = bus.car_present | ped_pending_q | bus.ped_req;
    side_entry    = 1'b0;
    side_exit     = 1'b0;

    case (state_q)
      MAIN_GRN: begin
        if (demand && (h_q >= MIN_MAIN_LIM)) state_d = MAIN_YLW;
      end
      MAIN_YLW: begin
        if (h_q >= YLW_LIM) state_d = (ALL_RED_TICKS == 0) ? SIDE_GRN : ALL_RED_A;
      end
      ALL_RED_A: begin
        if (h_q >= AR_LIM) state_d = SIDE_GRN;
      end
      SIDE_GRN: begin
        if ((h_q >= SIDE_MAX_LIM) ||
            ((h_q >= SIDE_MIN_LIM) && !bus.car_present &&
             (!serving_q || (h_q >= WALK_LIM))))
          state_d = SIDE_YLW;
      end
      SIDE_YLW: begin
        if (h_q >= YLW_LIM) state_d = (ALL_RED_TICKS == 0) ? MAIN_GRN : ALL_RED_B;
      end
      ALL_RED_B: begin
        if (h_q >= AR_LIM) state_d = MAIN_GRN;
      end
      default: state_d = MAIN_GRN;
    endcase

    // Hold counter restarts at 1 on every phase change and saturates.
    if (state_d != state_q) begin
      h_d = CNT_W'(1);
    end else if (h_q != H_MAX) begin
      h_d = h_q + CNT_W'(1);
    end

    // Pedestrian latch hands over to the serving flag as side green opens.
    side_entry = (state_d == SIDE_GRN) && (state_q != SIDE_GRN);
    side_exit  = (state_q == SIDE_GRN) && (state_d != SIDE_GRN);
    if (side_entry) begin
      serving_d     = ped_pending_q | bus.ped_req;
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_pending_q | bus.ped_req;
      if (side_exit) serving_d = 1'b0;
    end

    // Lamp decode from the phase being entered, so outputs are registered.
    case (state_d)
      MAIN_GRN: light_main_d = LT_GRN;
      MAIN_YLW: light_main_d = LT_YLW;
      SIDE_GRN: light_side_d = LT_GRN;
      SIDE_YLW: light_side_d = LT_YLW;
      default: begin
        light_main_d = LT_RED;
        light_side_d = LT_RED;
      end
    endcase
    walk_d = (state_d == SIDE_GRN) && serving_d && (h_d <= WALK_LIM);
  end

  assign bus.phase      = state_q;
  assign bus.light_main = light_main_q;
  assign bus.light_side = light_side_q;
  assign bus.walk       = walk_q;

endmodule

// File: tb/tb_stoplight_ctrl.sv
// Scoreboard bench for stoplight_ctrl: stimulus pushes the expected phase and
// walk for each edge, per-DUT monitors pop and compare at the falling edge.
module tb_stoplight_ctrl;

  typedef struct {
    string      name;
    logic [2:0] phase;
    logic       walk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  event sample0;

  always #5 clk = ~clk;

  stoplight_if bus0 ();
  stoplight_if bus1 ();

  stoplight_ctrl dut0 (.clk(clk), .rst(rst), .bus(bus0));
  stoplight_ctrl #(.ALL_RED_TICKS(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Expected-phase tables, entry i is the phase after edge i+1.
  int ph_car[16]   = '{0,0,0,1,2,3,3,3,3,4,5,0,0,0,0,1};
  int car_pls[11]  = '{1,1,0,0,1,1,0,0,0,0,0};
  int ph_pls[11]   = '{0,0,0,0,1,2,3,3,4,5,0};
  int ped_ped[20]  = '{1,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int ph_ped[20]   = '{0,0,0,1,2,3,3,3,4,5,0,0,0,0,1,2,3,3,3,4};
  int w_ped[20]    = '{0,0,0,0,0,1,1,1,0,0,0,0,0,0,0,0,1,1,1,0};
  int ph_ar0[15]   = '{0,0,0,1,3,3,3,3,4,0,0,0,0,1,3};

  function automatic logic [2:0] main_lamp(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b100;
      3'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input logic [2:0] ph);
    case (ph)
      3'd3:    return 3'b100;
      3'd4:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_entry(input exp_t e, input logic [2:0] ph, input logic [2:0] lm,
                           input logic [2:0] ls, input logic w);
    chk({e.name, " phase"}, 8'(ph), 8'(e.phase));
    chk({e.name, " main"},  8'(lm), 8'(main_lamp(e.phase)));
    chk({e.name, " side"},  8'(ls), 8'(side_lamp(e.phase)));
    chk({e.name, " walk"},  8'(w),  8'(e.walk));
  endtask

  // Monitor for the default instance.
  always begin
    exp_t e;
    @(negedge clk or sample0);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk_entry(e, bus0.phase, bus0.light_main, bus0.light_side, bus0.walk);
    end
  end

  // Monitor for the instance without all-red phases.
  always begin
    exp_t e;
    @(negedge clk);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk_entry(e, bus1.phase, bus1.light_main, bus1.light_side, bus1.walk);
    end
  end

  function automatic exp_t mk(input string nm, input int ph, input int w);
    exp_t e;
    e.name  = nm;
    e.phase = 3'(ph);
    e.walk  = 1'(w);
    return e;
  endfunction

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.car_present = 1'b0;
    bus0.ped_req     = 1'b0;
    bus1.car_present = 1'b0;
    bus1.ped_req     = 1'b0;
    q0.push_back(mk({nm, " rst"}, 0, 0));
    q1.push_back(mk({nm, " rst"}, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic step0(input int car, input int ped, input int ph, input int w, input string nm);
    bus0.car_present = 1'(car);
    bus0.ped_req     = 1'(ped);
    @(posedge clk);
    #1;
    q0.push_back(mk(nm, ph, w));
  endtask

  task automatic step1(input int car, input int ph, input string nm);
    bus1.car_present = 1'(car);
    bus1.ped_req     = 1'b0;
    @(posedge clk);
    #1;
    q1.push_back(mk(nm, ph, 0));
  endtask

  initial begin
    bus0.car_present = 1'b0;
    bus0.ped_req     = 1'b0;
    bus1.car_present = 1'b0;
    bus1.ped_req     = 1'b0;

    // Idle: main green holds indefinitely.
    do_reset("idle");
    for (int i = 0; i < 20; i++) step0(0, 0, 0, 0, $sformatf("idle e%0d", i + 1));

    // Continuous car: max-green cap, then minimum main green again.
    do_reset("car");
    for (int i = 0; i < 16; i++) step0(1, 0, ph_car[i], 0, $sformatf("car e%0d", i + 1));

    // Short pulse cancelled before minimum, later pulse accepted.
    do_reset("pulse");
    for (int i = 0; i < 11; i++)
      step0(car_pls[i], 0, ph_pls[i], 0, $sformatf("pulse e%0d", i + 1));

    // Pedestrian: walk for three ticks; request during side green served next cycle.
    do_reset("ped");
    for (int i = 0; i < 20; i++)
      step0(0, ped_ped[i], ph_ped[i], w_ped[i], $sformatf("ped e%0d", i + 1));

    // Asynchronous reset in the middle of a walk.
    do_reset("async");
    for (int i = 0; i < 7; i++)
      step0(0, ped_ped[i], ph_ped[i], w_ped[i], $sformatf("async e%0d", i + 1));
    #5;
    rst = 1'b0;
    #1;
    q0.push_back(mk("async mid-walk", 0, 0));
    -> sample0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Instance without all-red clearance.
    do_reset("ar0");
    for (int i = 0; i < 15; i++) step1(1, ph_ar0[i], $sformatf("ar0 e%0d", i + 1));
    bus1.car_present = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("queues drained", 8'(q0.size() + q1.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
